// File: rtl/doppler_tracker_mc.sv
// -----------------------------------------------------------------------------
// doppler_tracker_mc
//   Multi-channel Doppler velocity tracker. Each accepted radar point carries a
//   16-bit phase and a channel id. The block differences the phase against the
//   last phase seen on that channel (modulo 2^16, signed), scales the
//   difference to a velocity with saturation, and optionally smooths it per
//   channel with an exponential filter.
//
//   Pipeline: S1 (phase difference) -> output register. Both stages advance
//   only when the output register is empty or being consumed.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   in_valid     in   clean_point carries a point
//   in_ready     out  point accepted this cycle when in_valid is high
//   clean_point  in   128-bit radar point (phase and channel-id fields)
//   flush        in   clear all per-channel history
//   velocity     out  signed 16-bit velocity
//   vel_ch       out  channel of velocity (zero-extended)
//   vel_first    out  result is the first sample of its channel
//   vel_sat      out  velocity was clamped
//   vel_valid    out  output is valid
//   vel_ready    in   downstream accepts the output
// -----------------------------------------------------------------------------
module doppler_tracker_mc #(
    parameter int NUM_CH       = 4,
    parameter int PHASE_OFFSET = 0,
    parameter int CH_OFFSET    = 120,
    parameter int VEL_SCALE    = 256,
    parameter int VEL_SHIFT    = 8,
    parameter int AVG_SHIFT    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       clean_point,
    input  logic               flush,
    output logic signed [15:0] velocity,
    output logic [3:0]         vel_ch,
    output logic               vel_first,
    output logic               vel_sat,
    output logic               vel_valid,
    input  logic               vel_ready
);

    localparam int                CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // With a single channel every point maps to index 0.
    localparam logic [CH_W-1:0]   CH_MASK = CH_W'(NUM_CH - 1);
    localparam logic signed [15:0] SCALE_C = 16'(VEL_SCALE);

    // Phase difference modulo 2^16 reinterpreted as signed handles both the
    // 0x7FFF/0x8000 and 0xFFFF/0x0000 wrap points.
    function automatic logic signed [15:0] phase_diff(input logic [15:0] cur,
                                                      input logic [15:0] prev);
        logic [15:0] raw;
        raw        = cur - prev;
        phase_diff = $signed(raw);
    endfunction

    // Clamp a 32-bit value to 16-bit signed; bit 16 flags that clamping happened.
    function automatic logic [16:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            sat16 = {1'b1, 16'h7FFF};
        end else if (v < -32'sd32768) begin
            sat16 = {1'b1, 16'h8000};
        end else begin
            sat16 = {1'b0, v[15:0]};
        end
    endfunction

    // avg + ((x - avg) >>> AVG_SHIFT) with a 17-bit difference so the
    // subtraction cannot overflow; the result always lies between avg and x.
    function automatic logic signed [15:0] smooth(input logic signed [15:0] avg,
                                                  input logic signed [15:0] x);
        logic signed [16:0] delta;
        logic signed [16:0] stepv;
        logic signed [16:0] sum;
        delta  = {x[15], x} - {avg[15], avg};
        stepv  = delta >>> AVG_SHIFT;
        sum    = {avg[15], avg} + stepv;
        smooth = sum[15:0];
    endfunction

    // Stage S1 registers
    logic                     s1_valid_q, s1_valid_d;
    logic signed [15:0]       s1_diff_q,  s1_diff_d;
    logic                     s1_first_q, s1_first_d;
    logic [CH_W-1:0]          s1_ch_q,    s1_ch_d;

    // Output registers
    logic                     vel_valid_q, vel_valid_d;
    logic signed [15:0]       vel_q,       vel_d;
    logic [3:0]               vel_ch_q,    vel_ch_d;
    logic                     vel_first_q, vel_first_d;
    logic                     vel_sat_q,   vel_sat_d;

    // Per-channel history
    logic [15:0]              prev_phase_q [NUM_CH];
    logic [15:0]              prev_phase_d [NUM_CH];
    logic [NUM_CH-1:0]        seen_q, seen_d;
    logic signed [15:0]       avg_q [NUM_CH];
    logic signed [15:0]       avg_d [NUM_CH];

    // Combinational helpers
    logic                     en_s;
    logic                     accept_s;
    logic [15:0]              phase_s;
    logic [CH_W-1:0]          ch_s;
    logic                     first_s;
    logic signed [15:0]       diff_s;
    logic signed [31:0]       prod_s;
    logic signed [31:0]       scaled_s;
    logic [16:0]              sat_s;
    logic signed [15:0]       result_s;

    // Handshake and S1 input: field extraction and phase difference.
    always_comb begin
        en_s     = !vel_valid_q || vel_ready;
        accept_s = in_valid && en_s;
        phase_s  = clean_point[PHASE_OFFSET +: 16];
        ch_s     = clean_point[CH_OFFSET +: CH_W] & CH_MASK;
        // A flush in the accept cycle makes this point the channel's first.
        first_s  = flush || !seen_q[ch_s];
        if (first_s) begin
            diff_s = 16'sd0;
        end else begin
            diff_s = phase_diff(phase_s, prev_phase_q[ch_s]);
        end
    end

    // Output-stage arithmetic: gain, shift, saturate, optional smoothing.
    always_comb begin
        prod_s   = $signed({{16{s1_diff_q[15]}}, s1_diff_q}) *
                   $signed({{16{SCALE_C[15]}}, SCALE_C});
        scaled_s = prod_s >>> VEL_SHIFT;
        sat_s    = sat16(scaled_s);
        if ((AVG_SHIFT > 0) && !s1_first_q) begin
            result_s = smooth(avg_q[s1_ch_q], $signed(sat_s[15:0]));
        end else begin
            result_s = $signed(sat_s[15:0]);
        end
    end

    // Next-state for both pipeline stages and the per-channel history.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_diff_d    = s1_diff_q;
        s1_first_d   = s1_first_q;
        s1_ch_d      = s1_ch_q;
        vel_valid_d  = vel_valid_q;
        vel_d        = vel_q;
        vel_ch_d     = vel_ch_q;
        vel_first_d  = vel_first_q;
        vel_sat_d    = vel_sat_q;
        prev_phase_d = prev_phase_q;
        seen_d       = seen_q;
        avg_d        = avg_q;

        if (en_s) begin
            s1_valid_d  = accept_s;
            s1_diff_d   = diff_s;
            s1_first_d  = first_s;
            s1_ch_d     = ch_s;
            vel_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                vel_d       = result_s;
                vel_ch_d    = 4'(s1_ch_q);
                vel_first_d = s1_first_q;
                vel_sat_d   = sat_s[16];
                if (AVG_SHIFT > 0) begin
                    avg_d[s1_ch_q] = result_s;
                end else begin
                    avg_d = avg_q;
                end
            end else begin
                vel_d = vel_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Flush wins over the output-stage average write at the same edge.
        if (flush) begin
            seen_d = {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                avg_d[c] = 16'sd0;
            end
        end else begin
            seen_d = seen_d;
        end

        // Accept updates history at the same edge so the next point on this
        // channel differences against this phase.
        if (accept_s) begin
            prev_phase_d[ch_s] = phase_s;
            seen_d[ch_s]       = 1'b1;
        end else begin
            seen_d = seen_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= 16'sd0;
            s1_first_q  <= 1'b0;
            s1_ch_q     <= {CH_W{1'b0}};
            vel_valid_q <= 1'b0;
            vel_q       <= 16'sd0;
            vel_ch_q    <= 4'd0;
            vel_first_q <= 1'b0;
            vel_sat_q   <= 1'b0;
            seen_q      <= {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                prev_phase_q[c] <= 16'h0000;
                avg_q[c]        <= 16'sd0;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_diff_q    <= s1_diff_d;
            s1_first_q   <= s1_first_d;
            s1_ch_q      <= s1_ch_d;
            vel_valid_q  <= vel_valid_d;
            vel_q        <= vel_d;
            vel_ch_q     <= vel_ch_d;
            vel_first_q  <= vel_first_d;
            vel_sat_q    <= vel_sat_d;
            seen_q       <= seen_d;
            prev_phase_q <= prev_phase_d;
            avg_q        <= avg_d;
        end
    end

    assign in_ready  = en_s;
    assign velocity  = vel_q;
    assign vel_ch    = vel_ch_q;
    assign vel_first = vel_first_q;
    assign vel_sat   = vel_sat_q;
    assign vel_valid = vel_valid_q;

endmodule

// File: tb/tb_doppler_tracker_mc.sv
// -----------------------------------------------------------------------------
// tb_doppler_tracker_mc
//   Three tracker instances (gain 256 no smoothing, gain 1024 no smoothing,
//   gain 256 with AVG_SHIFT=2) driven one at a time. A transaction-level model
//   computes each expected result at accept time with integer arithmetic and
//   queues it; results are compared at every output handshake.
// -----------------------------------------------------------------------------
module tb_doppler_tracker_mc;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  ch;
        logic        first;
        logic        sat;
        int          acc;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [127:0] cp         [3];
    logic         flush      [3];
    logic [15:0]  vel        [3];
    logic [3:0]   vch        [3];
    logic         vel_first  [3];
    logic         vel_sat    [3];
    logic         vel_valid  [3];
    logic         vel_ready  [3];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   chk_lat = 1'b0;
    res_t expq [$];

    int   prev_m [3][4];
    bit   seen_m [3][4];
    int   avg_m  [3][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        doppler_tracker_mc #(
            .NUM_CH      (4),
            .PHASE_OFFSET(0),
            .CH_OFFSET   (120),
            .VEL_SCALE   ((g == 1) ? 1024 : 256),
            .VEL_SHIFT   (8),
            .AVG_SHIFT   ((g == 2) ? 2 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .clean_point(cp[g]),
            .flush      (flush[g]),
            .velocity   (vel[g]),
            .vel_ch     (vch[g]),
            .vel_first  (vel_first[g]),
            .vel_sat    (vel_sat[g]),
            .vel_valid  (vel_valid[g]),
            .vel_ready  (vel_ready[g])
        );
    end

    function automatic int scale_of(int k);
        return (k == 1) ? 1024 : 256;
    endfunction

    function automatic int ashift_of(int k);
        return (k == 2) ? 2 : 0;
    endfunction

    function automatic void model_flush(int k);
        for (int c = 0; c < 4; c++) begin
            seen_m[k][c] = 1'b0;
            avg_m[k][c]  = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            model_flush(k);
            for (int c = 0; c < 4; c++) prev_m[k][c] = 0;
        end
        expq.delete();
    endfunction

    function automatic res_t model_accept(int k, int p, int chf, bit fl, int at);
        res_t r;
        int   ch, d, s, o;
        bit   first;
        if (fl) model_flush(k);
        ch    = chf % 4;
        first = !seen_m[k][ch];
        if (first) begin
            d = 0;
        end else begin
            d = (p - prev_m[k][ch]) & 65535;
            if (d > 32767) d = d - 65536;
        end
        prev_m[k][ch] = p & 65535;
        seen_m[k][ch] = 1'b1;
        s     = (d * scale_of(k)) >>> 8;
        r.sat = (s > 32767) || (s < -32768);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (ashift_of(k) > 0) begin
            o = first ? s : avg_m[k][ch] + ((s - avg_m[k][ch]) >>> ashift_of(k));
            avg_m[k][ch] = o;
        end else begin
            o = s;
        end
        r.v     = o[15:0];
        r.ch    = ch[3:0];
        r.first = first;
        r.acc   = at;
        return r;
    endfunction

    function automatic logic [127:0] mkpt(int p, int chf);
        logic [127:0] v;
        v           = {$urandom, $urandom, $urandom, $urandom};
        v[15:0]     = p[15:0];
        v[123:120]  = chf[3:0];
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, score any handshake, update model, advance.
    task automatic step(int k, bit iv, int p, int chf, bit fl, bit vr);
        res_t        e;
        bit          hold;
        logic [15:0] sv;
        logic [3:0]  sc;
        logic        sf, ss;
        in_valid[k]  = iv;
        cp[k]        = mkpt(p, chf);
        flush[k]     = fl;
        vel_ready[k] = vr;
        #1;
        if (vel_valid[k] && vr) begin
            if (expq.size() == 0) begin
                chk("spurious_output", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("velocity",  32'(vel[k]),       32'(e.v));
                chk("vel_ch",    32'(vch[k]),       32'(e.ch));
                chk("vel_first", 32'(vel_first[k]), 32'(e.first));
                chk("vel_sat",   32'(vel_sat[k]),   32'(e.sat));
                if (chk_lat) chk("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
        hold = vel_valid[k] && !vr;
        sv = vel[k]; sc = vch[k]; sf = vel_first[k]; ss = vel_sat[k];
        if (iv && in_ready[k]) begin
            expq.push_back(model_accept(k, p, chf, fl, cyc));
        end else if (fl) begin
            model_flush(k);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", 32'(vel_valid[k]), 32'd1);
            chk("hold_vel",   32'(vel[k]),       32'(sv));
            chk("hold_ch",    32'(vch[k]),       32'(sc));
            chk("hold_first", 32'(vel_first[k]), 32'(sf));
            chk("hold_sat",   32'(vel_sat[k]),   32'(ss));
        end
        in_valid[k] = 1'b0;
        flush[k]    = 1'b0;
    endtask

    task automatic drain(int k);
        for (int i = 0; i < 20 && expq.size() > 0; i++) step(k, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        bit acc;
        int ph [3];
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; flush[k] = 1'b0; vel_ready[k] = 1'b1; cp[k] = 128'd0;
        end
        @(negedge clk);
        do_reset();

        // Idle after reset: outputs cleared, ready high, nothing valid.
        for (int k = 0; k < 3; k++) begin
            chk("rst_velocity", 32'(vel[k]),       32'd0);
            chk("rst_vel_ch",   32'(vch[k]),       32'd0);
            chk("rst_first",    32'(vel_first[k]), 32'd0);
            chk("rst_sat",      32'(vel_sat[k]),   32'd0);
            chk("rst_valid",    32'(vel_valid[k]), 32'd0);
            chk("rst_in_ready", 32'(in_ready[k]),  32'd1);
        end
        repeat (3) step(0, 1'b0, 0, 0, 1'b0, 1'b1);

        // ch0 basic difference, two-cycle latency.
        chk_lat = 1'b1;
        step(0, 1'b1, 16'h1000, 0, 1'b0, 1'b1);
        step(0, 1'b1, 16'h1400, 4, 1'b0, 1'b1);
        drain(0);

        // ch1 wrap across 0x7FFF/0x8000, and across 0xFFFF/0x0000 on ch3.
        step(0, 1'b1, 16'h7FF0, 1, 1'b0, 1'b1);
        step(0, 1'b1, 16'h8010, 1, 1'b0, 1'b1);
        step(0, 1'b1, 16'h7FF0, 9, 1'b0, 1'b1);
        step(0, 1'b1, 16'hFFF0, 3, 1'b0, 1'b1);
        step(0, 1'b1, 16'h0010, 3, 1'b0, 1'b1);
        drain(0);

        // Gain 1024: positive and negative saturation.
        step(1, 1'b1, 16'h0000, 0, 1'b0, 1'b1);
        step(1, 1'b1, 16'h4000, 0, 1'b0, 1'b1);
        step(1, 1'b1, 16'h0000, 0, 1'b0, 1'b1);
        drain(1);

        // Backpressure: 5 stalled cycles with 3 points offered.
        chk_lat = 1'b0;
        ph[0] = 16'h2000; ph[1] = 16'h2100; ph[2] = 16'h1F00;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            vel_ready[0] = 1'b0;
            #1;
            if (c >= 2) chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
            acc = (sent < 3) && in_ready[0];
            step(0, sent < 3, ph[sent % 3], 2, 1'b0, 1'b0);
            if (acc) sent++;
        end
        for (int c = 0; c < 10 && sent < 3; c++) begin
            vel_ready[0] = 1'b1;
            #1;
            acc = in_ready[0];
            step(0, 1'b1, ph[sent], 2, 1'b0, 1'b1);
            if (acc) sent++;
        end
        chk("stall_all_sent", 32'(sent), 32'd3);
        drain(0);

        // Smoothing on ch2, then flush with a new point.
        chk_lat = 1'b1;
        step(2, 1'b1, 0,    2, 1'b0, 1'b1);
        step(2, 1'b1, 400,  2, 1'b0, 1'b1);
        step(2, 1'b1, 800,  2, 1'b0, 1'b1);
        step(2, 1'b1, 1200, 2, 1'b0, 1'b1);
        step(2, 1'b1, 1600, 2, 1'b1, 1'b1);
        drain(2);

        // Reset mid-operation discards the in-flight point.
        step(0, 1'b1, 16'h5555, 1, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_valid", 32'(vel_valid[0]), 32'd0);
            step(0, 1'b0, 0, 0, 1'b0, 1'b1);
        end
        step(0, 1'b1, 16'h1234, 1, 1'b0, 1'b1);
        drain(0);

        // Randomized traffic with backpressure and occasional flush.
        chk_lat = 1'b0;
        for (int kk = 0; kk < 3; kk += 2) begin
            for (int i = 0; i < 400; i++) begin
                bit vr, iv, fl;
                vr = ($urandom % 4) != 0;
                iv = ($urandom % 3) != 0;
                fl = (($urandom % 25) == 0) && (!vel_valid[kk] || vr);
                step(kk, iv, int'($urandom % 65536), int'($urandom % 16), fl, vr);
            end
            drain(kk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
